// File: rtl/pc_branch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: sequential PC+4 fetch with
// valid/ready handshake, stall hold, taken-branch redirect with flush, misalign lockout.
module pc_branch_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_imm,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic            flush,
  output logic            misalign
);

  // state    | meaning
  // BOOT     | first cycle after reset release, no request
  // FETCH    | request pc_q, advance on handshake
  // HOLD     | stalled, request dropped, pc_q frozen
  // REDIRECT | flush cycle after a taken branch, pc_q holds target
  // TRAP     | misaligned target seen; frozen until reset
  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_REDIRECT,
    S_TRAP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_d;
  logic            if_valid_d, flush_d, misalign_d;
  logic [XLEN-1:0] tgt, seq_pc;
  logic            take, xfer;

  // The shift binds to the immediate; the carry out of the sum is dropped.
  assign tgt    = branch_pc + {branch_imm[XLEN-2:0], 1'b0};
  assign seq_pc = pc_q + XLEN'(INSTR_BYTES);
  assign take   = branch_valid && branch_taken && (state_q != S_TRAP);
  assign xfer   = imem_req && imem_ready;
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc;
    if_valid_d = 1'b0;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    imem_req   = (state_q == S_FETCH) && !stall;

    if (take) begin
      // A handshake coinciding with a redirect is discarded: no if_valid, no +4.
      flush_d = 1'b1;
      if (tgt[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = S_TRAP;
      end else begin
        pc_d    = tgt;
        state_d = S_REDIRECT;
      end
    end else begin
      case (state_q)
        S_BOOT:     state_d = S_FETCH;
        S_FETCH: begin
          if (stall) begin
            state_d = S_HOLD;
          end else if (xfer) begin
            pc_d       = seq_pc;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
          end
        end
        S_HOLD:     if (!stall) state_d = S_FETCH;
        S_REDIRECT: state_d = stall ? S_HOLD : S_FETCH;
        S_TRAP:     state_d = S_TRAP;
        default:    state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if_valid <= if_valid_d;
      if_pc    <= if_pc_d;
      flush    <= flush_d;
      misalign <= misalign_d;
    end
  end

endmodule
